// File: rtl/fpu_dispatch.sv
// fpu_dispatch: issue/retire front end for the FP cluster.
// Accepts one op per cycle, issues it to the selected functional unit,
// buffers one result per unit and retires results strictly in issue order
// through a registered output stage.
// Optional feature macro: FPU_DISPATCH_PERF_EN adds perf_issued/perf_stall
// saturating counters.
module fpu_dispatch #(
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned N_UNITS = 7,
  parameter  int unsigned DEPTH   = 4,
  localparam int unsigned OPW     = $clog2(N_UNITS + 1),
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic                       CLK,
  input  logic                       INITIALIZE,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPW-1:0]             in_op,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic [N_UNITS-1:0]         u_valid,
  input  logic [N_UNITS-1:0]         u_ready,
  output logic [WIDTH-1:0]           u_a,
  output logic [WIDTH-1:0]           u_b,
  input  logic [N_UNITS-1:0]         u_res_valid,
  input  logic [N_UNITS*WIDTH-1:0]   u_res_data,
  output logic [N_UNITS-1:0]         u_res_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [OPW-1:0]             out_op,
  output logic                       out_err,
  output logic [CW-1:0]              outstanding
`ifdef FPU_DISPATCH_PERF_EN
  ,
  output logic [31:0]                perf_issued,
  output logic [31:0]                perf_stall
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic           illegal;
    logic [OPW-1:0] op;
  } entry_t;

  // Order FIFO
  entry_t         fifo_mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           fifo_full;
  logic           fifo_empty;

  // Per-unit result buffers and in-flight counters
  logic [N_UNITS-1:0] buf_valid;
  logic [WIDTH-1:0]   buf_data [N_UNITS];
  logic [CW-1:0]      cnt      [N_UNITS];

  logic               op_legal;
  logic               unit_rdy;
  logic               accept;
  logic [N_UNITS-1:0] inc;
  logic [N_UNITS-1:0] capture;
  logic [N_UNITS-1:0] retire_hit;
  entry_t             head;
  logic               head_rdy;
  logic [WIDTH-1:0]   head_data;
  logic               retire;

  assign fifo_full   = (count == CW'(DEPTH));
  assign fifo_empty  = (count == '0);
  assign u_a         = in_a;
  assign u_b         = in_b;
  assign u_res_ready = ~buf_valid;
  assign accept      = in_valid && in_ready;
  assign outstanding = count + CW'(out_valid);

  // Issue decode: one-hot strobe and acceptance for the selected unit
  always_comb begin
    op_legal = (in_op < OPW'(N_UNITS));
    unit_rdy = 1'b0;
    u_valid  = '0;
    inc      = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (in_op == OPW'(k)) begin
        unit_rdy   = u_ready[k];
        u_valid[k] = in_valid && !fifo_full;
      end
    end
    in_ready = !fifo_full && (unit_rdy || !op_legal);
    for (int k = 0; k < N_UNITS; k++) begin
      inc[k] = u_valid[k] && in_ready;
    end
  end

  // Result capture: only results some issued op is waiting for are kept
  always_comb begin
    capture = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      capture[k] = u_res_valid[k] && !buf_valid[k] && (cnt[k] != '0);
    end
  end

  // Head-of-order readiness and retire decision
  always_comb begin
    head       = fifo_mem[rd_ptr];
    head_rdy   = head.illegal;
    head_data  = '0;
    retire_hit = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (!head.illegal && head.op == OPW'(k)) begin
        head_rdy  = buf_valid[k];
        head_data = buf_data[k];
      end
    end
    retire = !fifo_empty && head_rdy && (!out_valid || out_ready);
    for (int k = 0; k < N_UNITS; k++) begin
      retire_hit[k] = retire && !head.illegal && (head.op == OPW'(k));
    end
  end

  // Order FIFO storage (no reset needed; guarded by count)
  always_ff @(posedge CLK) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= '{illegal: !op_legal, op: in_op};
    end
  end

  // Order FIFO pointers and occupancy
  always_ff @(posedge CLK or posedge INITIALIZE) begin
    if (INITIALIZE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (retire) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(retire);
    end
  end

  // Per-unit result buffers and in-flight counters
  always_ff @(posedge CLK or posedge INITIALIZE) begin
    if (INITIALIZE) begin
      buf_valid <= '0;
      for (int k = 0; k < N_UNITS; k++) begin
        buf_data[k] <= '0;
        cnt[k]      <= '0;
      end
    end else begin
      for (int k = 0; k < N_UNITS; k++) begin
        if (capture[k]) begin
          buf_valid[k] <= 1'b1;
          buf_data[k]  <= u_res_data[k*WIDTH +: WIDTH];
        end else if (retire_hit[k]) begin
          buf_valid[k] <= 1'b0;
        end
        cnt[k] <= cnt[k] + CW'(inc[k]) - CW'(capture[k]);
      end
    end
  end

  // Registered output stage; holds while stalled
  always_ff @(posedge CLK or posedge INITIALIZE) begin
    if (INITIALIZE) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= '0;
      out_err   <= 1'b0;
    end else if (retire) begin
      out_valid <= 1'b1;
      out_data  <= head.illegal ? '0 : head_data;
      out_op    <= head.op;
      out_err   <= head.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FPU_DISPATCH_PERF_EN
  // Saturating accepted-op and stall-cycle counters
  always_ff @(posedge CLK or posedge INITIALIZE) begin
    if (INITIALIZE) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept && (perf_issued != '1)) perf_issued <= perf_issued + 32'd1;
      if (in_valid && !in_ready && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed, scoreboard-based bench for fpu_dispatch.
module tb_fpu_dispatch;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned N_UNITS = 7;
  localparam int unsigned OPW     = 3;
  localparam int unsigned CW      = 3;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [OPW-1:0]   op;
    logic             err;
  } exp_t;

  logic                     CLK;
  logic                     INITIALIZE;
  logic                     in_valid;
  logic                     in_ready;
  logic [OPW-1:0]           in_op;
  logic [WIDTH-1:0]         in_a;
  logic [WIDTH-1:0]         in_b;
  logic [N_UNITS-1:0]       u_valid;
  logic [N_UNITS-1:0]       u_ready;
  logic [WIDTH-1:0]         u_a;
  logic [WIDTH-1:0]         u_b;
  logic [N_UNITS-1:0]       u_res_valid;
  logic [N_UNITS*WIDTH-1:0] u_res_data;
  logic [N_UNITS-1:0]       u_res_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [OPW-1:0]           out_op;
  logic                     out_err;
  logic [CW-1:0]            outstanding;
`ifdef FPU_DISPATCH_PERF_EN
  logic [31:0]              perf_issued;
  logic [31:0]              perf_stall;
`endif

  int   errors = 0;
  int   total  = 0;
  exp_t q[$];

  fpu_dispatch dut (
    .CLK         (CLK),
    .INITIALIZE  (INITIALIZE),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .u_valid     (u_valid),
    .u_ready     (u_ready),
    .u_a         (u_a),
    .u_b         (u_b),
    .u_res_valid (u_res_valid),
    .u_res_data  (u_res_data),
    .u_res_ready (u_res_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_op      (out_op),
    .out_err     (out_err),
    .outstanding (outstanding)
`ifdef FPU_DISPATCH_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every completed output handshake against the queue
  always @(negedge CLK) begin
    if (!INITIALIZE && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", 64'(out_valid), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_data", 64'(out_data), 64'(e.data));
        check("sb_op",   64'(out_op),   64'(e.op));
        check("sb_err",  64'(out_err),  64'(e.err));
      end
    end
  end

  // Drive one op until accepted; checks the issue strobe on the way
  task automatic issue(input logic [OPW-1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    logic [N_UNITS-1:0] ev;
    n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    check("issue_timeout", 64'(n < 50), 64'(1));
    ev = '0;
    if (op < OPW'(N_UNITS)) ev[op] = 1'b1;
    check("u_valid", 64'(u_valid), 64'(ev));
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  // Present a unit result until the dispatcher takes it
  task automatic give_result(input int k, input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    u_res_valid[k] = 1'b1;
    u_res_data[k*WIDTH +: WIDTH] = d;
    #1;
    while (!u_res_ready[k] && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    check("result_timeout", 64'(n < 50), 64'(1));
    @(posedge CLK); #1;
    u_res_valid[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] held_data;
    INITIALIZE  = 1'b1;
    in_valid    = 1'b0;
    in_op       = '0;
    in_a        = '0;
    in_b        = '0;
    u_ready     = '1;
    u_res_valid = '0;
    u_res_data  = '0;
    out_ready   = 1'b1;

    // Reset state
    #3;
    check("rst_out_valid",   64'(out_valid),   64'(0));
    check("rst_out_data",    64'(out_data),    64'(0));
    check("rst_out_op",      64'(out_op),      64'(0));
    check("rst_out_err",     64'(out_err),     64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_u_res_ready", 64'(u_res_ready), 64'(7'h7f));
    repeat (2) @(posedge CLK);
    #1 INITIALIZE = 1'b0;
    @(posedge CLK); #1;

    // Single ADD, result 5 cycles later, out_valid two edges after result
    q.push_back('{data: 32'h40400000, op: 3'd1, err: 1'b0});
    in_valid = 1'b1; in_op = 3'd1; in_a = 32'h3F800000; in_b = 32'h40000000;
    #1;
    check("add_u_a", 64'(u_a), 64'(32'h3F800000));
    check("add_u_b", 64'(u_b), 64'(32'h40000000));
    check("add_in_ready", 64'(in_ready), 64'(1));
    check("add_u_valid", 64'(u_valid), 64'(7'b0000010));
    @(posedge CLK); #1;
    in_valid = 1'b0;
    check("add_outstanding", 64'(outstanding), 64'(1));
    repeat (4) @(posedge CLK);
    #1;
    u_res_valid[1] = 1'b1;
    u_res_data[1*WIDTH +: WIDTH] = 32'h40400000;
    #1;
    check("add_res_ready", 64'(u_res_ready[1]), 64'(1));
    @(posedge CLK); #1;
    u_res_valid[1] = 1'b0;
    check("add_valid_edge1", 64'(out_valid), 64'(0));
    @(posedge CLK); #1;
    check("add_valid_edge2", 64'(out_valid), 64'(1));
    check("add_data", 64'(out_data), 64'(32'h40400000));
    check("add_op",   64'(out_op),   64'(1));
    check("add_err",  64'(out_err),  64'(0));
    @(posedge CLK); #1;
    check("add_drained", 64'(outstanding), 64'(0));

    // Reorder: DIV then NEG; NEG held back until DIV retires
    q.push_back('{data: 32'h3F000000, op: 3'd4, err: 1'b0});
    issue(3'd4, 32'h3F800000, 32'h40000000);
    q.push_back('{data: 32'hBF800000, op: 3'd0, err: 1'b0});
    issue(3'd0, 32'h3F800000, 32'h0);
    give_result(0, 32'hBF800000);
    for (int i = 0; i < 18; i++) begin
      check("reorder_neg_held", 64'(u_res_ready[0]), 64'(0));
      check("reorder_no_out",   64'(out_valid),      64'(0));
      @(posedge CLK); #1;
    end
    u_res_valid[4] = 1'b1;
    u_res_data[4*WIDTH +: WIDTH] = 32'h3F000000;
    @(posedge CLK); #1;
    u_res_valid[4] = 1'b0;
    check("reorder_div_capt", 64'(out_valid), 64'(0));
    @(posedge CLK); #1;
    check("reorder_div_valid", 64'(out_valid), 64'(1));
    check("reorder_div_op",    64'(out_op),    64'(4));
    check("reorder_neg_still", 64'(u_res_ready[0]), 64'(0));
    @(posedge CLK); #1;
    check("reorder_neg_valid", 64'(out_valid), 64'(1));
    check("reorder_neg_op",    64'(out_op),    64'(0));
    check("reorder_neg_free",  64'(u_res_ready[0]), 64'(1));
    @(posedge CLK); #1;
    check("reorder_idle", 64'(out_valid), 64'(0));

    // Full FIFO: 4 MULs outstanding, 5th refused
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q.push_back('{data: 32'h1000 + 32'(i), op: 3'd2, err: 1'b0});
      issue(3'd2, 32'(i), 32'h2);
    end
    in_valid = 1'b1; in_op = 3'd2; in_a = 32'h5; in_b = 32'h2;
    #1;
    check("full_in_ready",    64'(in_ready),    64'(0));
    check("full_u_valid",     64'(u_valid),     64'(0));
    check("full_outstanding", 64'(outstanding), 64'(4));
    @(posedge CLK); #1;
    check("full_still4", 64'(outstanding), 64'(4));
    check("full_u_valid2", 64'(u_valid), 64'(0));
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) give_result(2, 32'h1000 + 32'(i));
    repeat (3) @(posedge CLK);
    #1;
    check("full_drained", 64'(outstanding), 64'(0));

    // Illegal op at an empty head
    q.push_back('{data: 32'h0, op: 3'd7, err: 1'b1});
    in_valid = 1'b1; in_op = 3'd7; in_a = 32'h12345678; in_b = 32'h9;
    #1;
    check("ill_in_ready", 64'(in_ready), 64'(1));
    check("ill_u_valid",  64'(u_valid),  64'(0));
    @(posedge CLK); #1;
    in_valid = 1'b0;
    check("ill_accept_valid", 64'(out_valid),   64'(0));
    check("ill_outstanding",  64'(outstanding), 64'(1));
    @(posedge CLK); #1;
    check("ill_valid", 64'(out_valid), 64'(1));
    check("ill_data",  64'(out_data),  64'(0));
    check("ill_err",   64'(out_err),   64'(1));
    check("ill_op",    64'(out_op),    64'(7));
    @(posedge CLK); #1;

    // Back-pressure: 3 results pending, output stalled 10 cycles
    out_ready = 1'b0;
    q.push_back('{data: 32'hA1, op: 3'd1, err: 1'b0});
    issue(3'd1, 32'h1, 32'h1);
    q.push_back('{data: 32'hB2, op: 3'd2, err: 1'b0});
    issue(3'd2, 32'h2, 32'h2);
    q.push_back('{data: 32'hC3, op: 3'd3, err: 1'b0});
    issue(3'd3, 32'h3, 32'h3);
    give_result(1, 32'hA1);
    give_result(2, 32'hB2);
    give_result(3, 32'hC3);
    held_data = out_data;
    check("bp_first_data", 64'(held_data), 64'(32'hA1));
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      check("bp_hold_valid", 64'(out_valid), 64'(1));
      check("bp_hold_data",  64'(out_data),  64'(32'hA1));
      check("bp_hold_op",    64'(out_op),    64'(1));
    end
    check("bp_outstanding", 64'(outstanding), 64'(3));
    out_ready = 1'b1;
    @(posedge CLK); #1;
    check("bp_drain2_valid", 64'(out_valid), 64'(1));
    check("bp_drain2_op",    64'(out_op),    64'(2));
    @(posedge CLK); #1;
    check("bp_drain3_valid", 64'(out_valid), 64'(1));
    check("bp_drain3_op",    64'(out_op),    64'(3));
    @(posedge CLK); #1;
    check("bp_idle", 64'(out_valid), 64'(0));

    // Asynchronous INITIALIZE with 3 ops outstanding
    out_ready = 1'b0;
    q.push_back('{data: 32'h77, op: 3'd1, err: 1'b0});
    issue(3'd1, 32'h7, 32'h7);
    issue(3'd2, 32'h8, 32'h8);
    issue(3'd3, 32'h9, 32'h9);
    give_result(1, 32'h77);
    @(posedge CLK); #1;
    check("init_pre_valid", 64'(out_valid),   64'(1));
    check("init_pre_outst", 64'(outstanding), 64'(3));
    #1 INITIALIZE = 1'b1;
    #1;
    check("init_out_valid",   64'(out_valid),   64'(0));
    check("init_out_data",    64'(out_data),    64'(0));
    check("init_out_op",      64'(out_op),      64'(0));
    check("init_outstanding", 64'(outstanding), 64'(0));
    check("init_res_ready",   64'(u_res_ready), 64'(7'h7f));
    q.delete();
    #1 INITIALIZE = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    give_result(2, 32'hDEAD);
    give_result(3, 32'hBEEF);
    for (int i = 0; i < 5; i++) begin
      check("late_no_out",      64'(out_valid),   64'(0));
      check("late_outstanding", 64'(outstanding), 64'(0));
      @(posedge CLK); #1;
    end
    check("late_res_ready", 64'(u_res_ready), 64'(7'h7f));

    check("sb_empty", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule

// File: doc/fpu_dispatch.md
# fpu_dispatch

Parametrised issue/retire front end for the floating-point cluster. It accepts one operation per cycle over a valid/ready handshake and issues it to one of `N_UNITS` functional units (add, sub, mul, div, sqrt, neg, cmp), each with its own latency. It tracks up to `DEPTH` operations in flight and returns results strictly in issue order through a registered output stage. It sits between the core's execute stage and the FPU unit instances.

## Interface
- `WIDTH`, 32: operand/result width.
- `N_UNITS`, 7: number of attached units; op code k selects unit k (NEG=0 … SQRT=6).
- `DEPTH`, 4: maximum outstanding operations; power of two, ≥2.
- `OPW`, `$clog2(N_UNITS+1)`: op-code width (derived, not overridden).

Ports:
- `CLK`  in  1  clock, rising edge.
- `INITIALIZE`  in  1  reset, asynchronous, active-high.
- `in_valid` / `in_ready`  in / out  1  operation handshake.
- `in_op`  in  OPW  target unit.
- `in_a`, `in_b`  in  WIDTH  operands.
- `u_valid`  out  N_UNITS  one-hot issue strobe.
- `u_ready`  in  N_UNITS  unit can accept.
- `u_a`, `u_b`  out  WIDTH  operands broadcast to all units.
- `u_res_valid`  in  N_UNITS  unit result valid.
- `u_res_data`  in  N_UNITS*WIDTH  unit k result in bits [k*WIDTH +: WIDTH].
- `u_res_ready`  out  N_UNITS  result accepted.
- `out_valid` / `out_ready`  out / in  1  result handshake.
- `out_data`  out  WIDTH  result.
- `out_op`  out  OPW  op code of the result.
- `out_err`  out  1  result belongs to an illegal op.
- `outstanding`  out  `$clog2(DEPTH+1)`  issued-but-not-retired count.

## Operation
- Order FIFO of `DEPTH` entries holds {op, illegal flag} for every accepted operation.
- Per-unit state: a one-entry result buffer and an in-flight counter `cnt[k]`.
- `u_a = in_a`, `u_b = in_b` (combinational).
- Legal op (`in_op < N_UNITS`):
  - `u_valid[k] = in_valid && in_op==k && !fifo_full`.
  - `in_ready = !fifo_full && u_ready[in_op]`.
- Illegal op (`in_op ≥ N_UNITS`):
  - `in_ready = !fifo_full`; no `u_valid` is raised.
  - The entry is pushed with the illegal flag set.
- Accept (`in_valid && in_ready`): push the order FIFO; for a legal op, `cnt[in_op]++`.
- Capture: `u_res_ready[k] = !buf_valid[k]`.
  - When `u_res_valid[k] && u_res_ready[k] && cnt[k]>0`: write buffer k and decrement `cnt[k]`.
  - When `cnt[k]==0` (spurious result): the result is consumed and dropped.
- Retire:
  - Head entry h is ready when illegal, or when `buf_valid[h]` is set.
  - Retire occurs when the head is ready and the output stage is empty or `out_ready` is high.
  - Retire pops the FIFO, clears `buf_valid[h]`, and loads the output stage.
  - Illegal entries load `out_data=0`, `out_err=1`.
- Simultaneous push and pop on a full FIFO: push is refused, because `in_ready` uses the registered full flag. Push and pop in the same cycle on a non-full FIFO keep the count unchanged.
- Pointers wrap modulo `DEPTH`.
- `outstanding` = FIFO count + output stage valid.
- A result held behind an older op on a different unit back-pressures only its own unit.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_op=0`, `out_err=0`, `outstanding=0`.
  - `u_res_ready` all 1; FIFO empty; all `cnt` and `buf_valid` cleared.
- Reset is asynchronous and may arrive mid-operation. Everything in flight is discarded; results arriving afterwards see `cnt==0` and are dropped.
- Issue is combinational: `u_valid` is asserted in the same cycle as `in_valid`.
- Unit result to `out_valid` when the head matches and the output is free: 2 edges (capture edge, then retire edge).
- Illegal op at an empty head: `out_valid` asserts 1 edge after accept.
- `out_data`, `out_op` and `out_err` are stable while `out_valid && !out_ready`.
- Throughput is 1 op/cycle when units are ready and results arrive in order.

## Configuration
- `FPU_DISPATCH_PERF_EN` defined:
  - Adds output `perf_issued` (32 bits): number of accepted ops.
  - Adds output `perf_stall` (32 bits): number of cycles with `in_valid && !in_ready`.
  - Both counters saturate at all-ones and reset to 0.
- Not defined: these ports and their logic are absent; behaviour is otherwise identical.

## Test plan
- Single ADD (op 1): a=0x3F800000, b=0x40000000; unit 1 returns 0x40400000 after 5 cycles. Require `out_valid` 2 edges after `u_res_valid`, `out_data`=0x40400000, `out_op`=1, `out_err`=0.
- Reorder: issue DIV (op 4, 20-cycle latency) then NEG (op 0, 1-cycle latency). The NEG result must be held with `u_res_ready[0]=0` until DIV retires, then NEG retires next cycle.
- Full FIFO: issue 4 MULs with `out_ready=0`. The 5th MUL sees `in_ready=0` and `outstanding=4`, and a 5th attempt must not raise `u_valid`.
- Illegal op 7 with no ops pending: accepted in 1 cycle; next edge `out_valid=1`, `out_data=0`, `out_err=1`.
- Back-pressure: `out_ready` low for 10 cycles with 3 results pending. Outputs stay stable, then the 3 results drain on consecutive cycles in issue order.
- Async `INITIALIZE` pulse with 3 ops outstanding: all outputs return to their reset values immediately. A late `u_res_valid` is dropped and no `out_valid` follows.
